// File: rtl/w0rm_core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : w0rm_core_pkg
//  Description : Shared writeback types: source-select encoding and entry
//                layout for the W0RM core register-file write path.
//  Revision    : 1.0  initial release
// ============================================================================
package w0rm_core_pkg;

    localparam int unsigned c_wb_data_width    = 32;
    localparam int unsigned c_wb_num_registers = 16;
    localparam int unsigned c_wb_addr_width    = $clog2(c_wb_num_registers);

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic [c_wb_addr_width-1:0] addr;
        logic [c_wb_data_width-1:0] data;
    } wb_entry_t;

    function automatic wb_src_e wb_other_src(input wb_src_e src);
        return (src == SRC_ALU) ? SRC_MEM : SRC_ALU;
    endfunction

endpackage
`default_nettype wire

// File: rtl/w0rm_core_wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : w0rm_core_wb_fifo
//  Description : Two-entry FIFO holding pending writeback results of one
//                source; read pointer plus occupancy count.
//  Revision    : 1.0  initial release
// ============================================================================
module w0rm_core_wb_fifo #(
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;
    logic             w_wr_ptr;

    assign full     = (r_count == 2'd2);
    assign empty    = (r_count == 2'd0);
    assign w_push   = push & ~full;
    assign w_pop    = pop & ~empty;
    // Tail slot sits one past the head when exactly one entry is held.
    assign w_wr_ptr = r_rd_ptr ^ r_count[0];
    assign head     = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/w0rm_core_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : w0rm_core_writeback
//  Description : Writeback stage: buffers ALU and memory results, arbitrates
//                round-robin and issues one register-file write per cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module w0rm_core_writeback
    import w0rm_core_pkg::*;
#(
    parameter  int DATA_WIDTH    = c_wb_data_width,
    parameter  int NUM_REGISTERS = c_wb_num_registers,
    localparam int ADDR_WIDTH    = $clog2(NUM_REGISTERS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_addr,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  rf_write_enable,
    output logic [ADDR_WIDTH-1:0] rf_write_addr,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    output logic                  fwd_valid,
    output logic [ADDR_WIDTH-1:0] fwd_addr,
    output logic [DATA_WIDTH-1:0] fwd_data,
    output logic                  busy
);

    localparam int c_entry_width = ADDR_WIDTH + DATA_WIDTH;

    logic                     w_alu_full, w_alu_empty, w_alu_push, w_alu_pop;
    logic                     w_mem_full, w_mem_empty, w_mem_push, w_mem_pop;
    logic [c_entry_width-1:0] w_alu_head, w_mem_head, w_grant_entry;
    logic                     w_grant;
    wb_src_e                  w_grant_src;
    wb_src_e                  r_last_grant;
    logic                     r_we;
    logic [ADDR_WIDTH-1:0]    r_addr;
    logic [DATA_WIDTH-1:0]    r_data;

    // Ready depends on registered occupancy only; reset forces it low.
    assign alu_ready  = ~w_alu_full & ~reset;
    assign mem_ready  = ~w_mem_full & ~reset;
    assign w_alu_push = alu_valid & alu_ready;
    assign w_mem_push = mem_valid & mem_ready;

    w0rm_core_wb_fifo #(
        .WIDTH (c_entry_width)
    ) u_alu_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_alu_push),
        .push_data ({alu_addr, alu_data}),
        .pop       (w_alu_pop),
        .full      (w_alu_full),
        .empty     (w_alu_empty),
        .head      (w_alu_head)
    );

    w0rm_core_wb_fifo #(
        .WIDTH (c_entry_width)
    ) u_mem_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_mem_push),
        .push_data ({mem_addr, mem_data}),
        .pop       (w_mem_pop),
        .full      (w_mem_full),
        .empty     (w_mem_empty),
        .head      (w_mem_head)
    );

    always_comb begin
        w_grant     = ~w_alu_empty | ~w_mem_empty;
        w_grant_src = SRC_ALU;
        if (!w_alu_empty && !w_mem_empty) begin
            w_grant_src = wb_other_src(r_last_grant);
        end else if (w_alu_empty) begin
            w_grant_src = SRC_MEM;
        end
    end

    assign w_alu_pop     = w_grant & (w_grant_src == SRC_ALU);
    assign w_mem_pop     = w_grant & (w_grant_src == SRC_MEM);
    assign w_grant_entry = (w_grant_src == SRC_MEM) ? w_mem_head : w_alu_head;

    // Address/data hold their last value when idle; only the strobe drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= SRC_ALU;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
        end else begin
            r_we <= w_grant;
            if (w_grant) begin
                r_last_grant     <= w_grant_src;
                {r_addr, r_data} <= w_grant_entry;
            end
        end
    end

    assign rf_write_enable = r_we;
    assign rf_write_addr   = r_addr;
    assign rf_write_data   = r_data;
    assign fwd_valid       = r_we;
    assign fwd_addr        = r_addr;
    assign fwd_data        = r_data;
    assign busy            = ~w_alu_empty | ~w_mem_empty | r_we;

endmodule
`default_nettype wire

// File: tb/tb_w0rm_core_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_w0rm_core_writeback
//  Description : Scoreboard bench for the writeback stage against a
//                queue-based reference of both FIFOs and the arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_w0rm_core_writeback;
    import w0rm_core_pkg::*;

    localparam int c_aw = 4;
    localparam int c_dw = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            alu_valid = 1'b0;
    logic [c_aw-1:0] alu_addr = '0;
    logic [c_dw-1:0] alu_data = '0;
    logic            mem_valid = 1'b0;
    logic [c_aw-1:0] mem_addr = '0;
    logic [c_dw-1:0] mem_data = '0;
    logic            alu_ready, mem_ready, rf_write_enable, fwd_valid, busy;
    logic [c_aw-1:0] rf_write_addr, fwd_addr;
    logic [c_dw-1:0] rf_write_data, fwd_data;

    always #5 clk = ~clk;

    w0rm_core_writeback #(
        .DATA_WIDTH    (c_dw),
        .NUM_REGISTERS (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .alu_valid       (alu_valid),
        .alu_ready       (alu_ready),
        .alu_addr        (alu_addr),
        .alu_data        (alu_data),
        .mem_valid       (mem_valid),
        .mem_ready       (mem_ready),
        .mem_addr        (mem_addr),
        .mem_data        (mem_data),
        .rf_write_enable (rf_write_enable),
        .rf_write_addr   (rf_write_addr),
        .rf_write_data   (rf_write_data),
        .fwd_valid       (fwd_valid),
        .fwd_addr        (fwd_addr),
        .fwd_data        (fwd_data),
        .busy            (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    // Reference state: per-source queues, last grant and the expected output.
    wb_entry_t       m_alu_q[$];
    wb_entry_t       m_mem_q[$];
    wb_entry_t       sb_q[$];
    wb_src_e         m_last = SRC_ALU;
    logic            m_we = 1'b0;
    int              m_accepts = 0;
    logic [c_dw-1:0] dut_rf [16];
    int              dut_writes = 0;

    task automatic model_reset();
        m_alu_q.delete();
        m_mem_q.delete();
        sb_q.delete();
        m_last = SRC_ALU;
        m_we   = 1'b0;
    endtask

    task automatic model_step();
        logic    take_alu, take_mem;
        wb_src_e src;
        take_alu = alu_valid && (m_alu_q.size() < 2);
        take_mem = mem_valid && (m_mem_q.size() < 2);
        if (m_alu_q.size() != 0 || m_mem_q.size() != 0) begin
            if (m_alu_q.size() != 0 && m_mem_q.size() != 0)
                src = (m_last == SRC_ALU) ? SRC_MEM : SRC_ALU;
            else
                src = (m_alu_q.size() != 0) ? SRC_ALU : SRC_MEM;
            if (src == SRC_ALU) sb_q.push_back(m_alu_q.pop_front());
            else                sb_q.push_back(m_mem_q.pop_front());
            m_last = src;
            m_we   = 1'b1;
        end else begin
            m_we = 1'b0;
        end
        if (take_alu) begin
            m_alu_q.push_back(wb_entry_t'({alu_addr, alu_data}));
            m_accepts++;
        end
        if (take_mem) begin
            m_mem_q.push_back(wb_entry_t'({mem_addr, mem_data}));
            m_accepts++;
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else       model_step();
    end

    task automatic monitor_step();
        wb_entry_t e;
        check_eq("alu_ready", 64'(alu_ready), 64'(m_alu_q.size() < 2));
        check_eq("mem_ready", 64'(mem_ready), 64'(m_mem_q.size() < 2));
        check_eq("wr_en", 64'(rf_write_enable), 64'(m_we));
        check_eq("fwd_valid", 64'(fwd_valid), 64'(m_we));
        check_eq("busy", 64'(busy), 64'(m_we || m_alu_q.size() != 0 || m_mem_q.size() != 0));
        if (m_we && sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_eq("wr_addr", 64'(rf_write_addr), 64'(e.addr));
            check_eq("wr_data", 64'(rf_write_data), 64'(e.data));
            check_eq("fwd_addr", 64'(fwd_addr), 64'(e.addr));
            check_eq("fwd_data", 64'(fwd_data), 64'(e.data));
        end
        if (rf_write_enable) begin
            dut_rf[rf_write_addr] = rf_write_data;
            dut_writes++;
        end
    endtask

    always @(negedge clk) begin
        if (!reset) monitor_step();
    end

    task automatic drive(input logic av, input logic [c_aw-1:0] aa, input logic [c_dw-1:0] ad,
                         input logic mv, input logic [c_aw-1:0] ma, input logic [c_dw-1:0] md);
        @(negedge clk);
        alu_valid = av;
        alu_addr  = aa;
        alu_data  = ad;
        mem_valid = mv;
        mem_addr  = ma;
        mem_data  = md;
    endtask

    task automatic drive_idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic drain(input string tag);
        int i = 0;
        while (busy && i < 32) begin
            @(negedge clk);
            #1;
            i++;
        end
        check_eq(tag, 64'(busy), 64'(0));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        int w0, a0, drops;
        for (int r = 0; r < 16; r++) dut_rf[r] = '0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_alu_ready", 64'(alu_ready), 64'(0));
        check_eq("rst_mem_ready", 64'(mem_ready), 64'(0));
        check_eq("rst_wr_en", 64'(rf_write_enable), 64'(0));
        check_eq("rst_fwd_valid", 64'(fwd_valid), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_wr_addr", 64'(rf_write_addr), 64'(0));
        check_eq("rst_wr_data", 64'(rf_write_data), 64'(0));
        check_eq("rst_fwd_data", 64'(fwd_data), 64'(0));
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check_eq("post_rst_alu_ready", 64'(alu_ready), 64'(1));
        check_eq("post_rst_mem_ready", 64'(mem_ready), 64'(1));

        // Single ALU write: visible two cycles after the drive edge.
        drive(1'b1, 4'd3, 32'h5A, 1'b0, '0, '0);
        drive_idle();
        @(negedge clk);
        #1;
        check_eq("t1_wr_en", 64'(rf_write_enable), 64'(1));
        check_eq("t1_wr_addr", 64'(rf_write_addr), 64'(3));
        check_eq("t1_wr_data", 64'(rf_write_data), 64'(32'h5A));
        @(negedge clk);
        #1;
        check_eq("t1_busy", 64'(busy), 64'(0));

        // First contention: memory wins, ALU next cycle.
        drive(1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22);
        drive_idle();
        @(negedge clk);
        #1;
        check_eq("t2_first_addr", 64'(rf_write_addr), 64'(2));
        check_eq("t2_first_data", 64'(rf_write_data), 64'(32'h22));
        @(negedge clk);
        #1;
        check_eq("t2_second_en", 64'(rf_write_enable), 64'(1));
        check_eq("t2_second_addr", 64'(rf_write_addr), 64'(1));
        check_eq("t2_second_data", 64'(rf_write_data), 64'(32'h11));
        drain("t2_drain");

        // Continuous contention for 10 cycles.
        w0 = dut_writes;
        a0 = m_accepts;
        drops = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 4'(i), 32'(32'hA00 + i), 1'b1, 4'(i + 8), 32'(32'hB00 + i));
            #1;
            if (!alu_ready || !mem_ready) drops++;
        end
        drive_idle();
        drain("t3_drain");
        check_eq("t3_backpressure_seen", 64'(drops > 0), 64'(1));
        check_eq("t3_write_count", 64'(dut_writes - w0), 64'(m_accepts - a0));

        // ALU streaming alone.
        w0 = dut_writes;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 4'(i), 32'(32'hC00 + i), 1'b0, '0, '0);
            #1;
            check_eq("t4_alu_ready", 64'(alu_ready), 64'(1));
        end
        drive_idle();
        drain("t4_drain");
        check_eq("t4_write_count", 64'(dut_writes - w0), 64'(8));

        // Same-address conflict from a fresh reset: ALU retires last.
        pulse_reset();
        drive(1'b1, 4'd5, 32'h5555, 1'b1, 4'd5, 32'hAAAA);
        drive_idle();
        drain("t5_drain");
        check_eq("t5_reg5_final", 64'(dut_rf[5]), 64'(32'h5555));

        // Reset while both FIFOs are loaded.
        for (int i = 0; i < 6; i++)
            drive(1'b1, 4'(i), 32'(32'hD00 + i), 1'b1, 4'(i + 8), 32'(32'hE00 + i));
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_eq("t6_rst_wr_en", 64'(rf_write_enable), 64'(0));
        check_eq("t6_rst_busy", 64'(busy), 64'(0));
        check_eq("t6_rst_alu_ready", 64'(alu_ready), 64'(0));
        check_eq("t6_rst_mem_ready", 64'(mem_ready), 64'(0));
        drive_idle();
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check_eq("t6_alu_ready_back", 64'(alu_ready), 64'(1));
        check_eq("t6_mem_ready_back", 64'(mem_ready), 64'(1));
        w0 = dut_writes;
        repeat (5) @(negedge clk);
        #1;
        check_eq("t6_no_stale_writes", 64'(dut_writes - w0), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/w0rm_core_writeback.md
# w0rm_core_writeback

Writeback stage of the W0RM core. It sits directly upstream of the register file write port. It accepts results from the ALU and the memory unit over valid/ready handshakes and buffers each source in a 2-entry FIFO. It arbitrates round-robin between the sources, drives exactly one register-file write per cycle, and mirrors that write on a forwarding port for operand bypass.

## Interface
Parameters:
- `DATA_WIDTH`, 32, register data width.
- `NUM_REGISTERS`, 16, register count; must be a power of two ≥ 2.
- `ADDR_WIDTH`, log2(`NUM_REGISTERS`), derived localparam, not overridable.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `alu_valid` / `alu_ready`  in / out  1  ALU result handshake.
- `alu_addr` / `alu_data`  in  `ADDR_WIDTH` / `DATA_WIDTH`  ALU destination register and value.
- `mem_valid` / `mem_ready`  in / out  1  memory-unit result handshake.
- `mem_addr` / `mem_data`  in  `ADDR_WIDTH` / `DATA_WIDTH`  memory destination register and value.
- `rf_write_enable`  out  1  register-file write strobe.
- `rf_write_addr` / `rf_write_data`  out  `ADDR_WIDTH` / `DATA_WIDTH`  register-file write address and data.
- `fwd_valid` / `fwd_addr` / `fwd_data`  out  1 / `ADDR_WIDTH` / `DATA_WIDTH`  copy of the `rf_write_*` signals, for bypass.
- `busy`  out  1  any FIFO non-empty or `rf_write_enable` high.

## Operation
- **Acceptance.** A transfer occurs on an edge where valid && ready.
  - `x_ready` = (count_x < 2).
  - Ready is computed from the registered count only; there is no combinational path from valid to ready.
- **FIFO.** Each source has a 2-entry FIFO: {addr, data}, a 1-bit pointer, and a 2-bit count.
  - Push and pop in the same cycle leave the count unchanged.
  - A push into a full FIFO cannot occur because ready is low.
- **Arbitration.** The state is a `last_grant` flop.
  - Only one FIFO non-empty: grant that FIFO.
  - Both non-empty: grant the source that is not `last_grant`.
  - `last_grant` updates on every grant.
  - Reset value is ALU, so memory wins the first contention.
- **Grant.** A grant pops the head and loads the output register at that edge. `rf_write_enable` is 1 for exactly the cycle after each grant edge, and 0 when no grant occurred.
- **Output idle values.** When idle, `rf_write_addr` and `rf_write_data` hold their last values. Consumers must qualify them with enable.
- **Forwarding.** `fwd_*` are wire copies of `rf_write_*`.
- **Ordering.** Order is preserved within a source. Across sources, writes retire in grant order; same-address writes from both sources resolve in grant order with no extra hazard logic.
- **Back-pressure.** The output never stalls.
  - Under continuous contention each source gets 1 write per 2 cycles.
  - Its FIFO fills and ready drops until it is granted.
- **Reset values.** While `reset` is high:
  - `alu_ready` = `mem_ready` = 0.
  - `rf_write_enable` = `fwd_valid` = `busy` = 0.
  - `rf_write_addr` = `fwd_addr` = 0 and `rf_write_data` = `fwd_data` = 0.
  - FIFO counts and pointers are 0.
- **After deassert.** Both ready signals are 1. Reset asserted mid-operation discards all buffered and in-flight results immediately (asynchronous).

## Timing
- **Latency, uncontended.** Handshake at edge k, grant at edge k+1, `rf_write_enable` high during cycle k+1..k+2, register file captures at edge k+2.
- **Latency, contended.** The loser adds 1 cycle per pending winner entry ahead of it.
- **Throughput.** Peak is 1 write per cycle in aggregate. A single source streaming alone sustains 1 per cycle with ready continuously high.
- **Ready drop.** Ready deasserts the cycle after the push that makes count = 2 without a same-edge pop.
- **Simultaneous pop and push** on a FIFO holding 1 entry: count stays 1; the new entry becomes the head next cycle.

## Structure
- **Shared package.** A shared `w0rm_core_pkg` holds:
  - the source-select encoding (SRC_ALU = 0, SRC_MEM = 1);
  - the writeback-entry struct type {addr, data}.
- **Sub-module.** `w0rm_core_wb_fifo`: a parameterised 2-entry FIFO (width, push, pop, full, empty, head), instantiated twice.
- **Top.** Holds the arbiter, the `last_grant` flop and the output register.

## Test plan
- **Single ALU write.** After reset: `alu_valid`=1, addr=3, data=0x5A for one cycle. Required: `rf_write_enable`=1 with addr=3, data=0x5A two cycles later; `busy` then 0.
- **First contention.** ALU (addr 1, 0x11) and MEM (addr 2, 0x22) in the same cycle. Required: MEM write first, ALU write on the next cycle.
- **Continuous contention.** Both sources valid every cycle for 10 cycles. Required:
  - writes alternate MEM/ALU;
  - each ready drops after the FIFO fills, then toggles;
  - no result lost or duplicated; per-source order matches issue order.
- **ALU stream alone.** 8 back-to-back results. Required: `alu_ready` stays 1; 8 consecutive write cycles with no gaps.
- **Same-address conflict.** ALU and MEM both target register 5 in the same cycle. Required: two writes in grant order, with the final value from the later grant.
- **Reset mid-stream.** Assert `reset` with both FIFOs full. Required: `rf_write_enable`, `busy` and both ready signals are 0 immediately. After deassert, both ready signals return to 1 and no stale writes occur.
